dds_sweep_ctrl: RTL



---
 rtl/dds_sweep_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the DDS frequency word.
// Steps Fword from a start word to a stop word with a programmable dwell per word.
module dds_sweep_ctrl #(
   parameter int FW_W    = 32,
   parameter int DWELL_W = 24
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Cont,
   input  logic [FW_W-1:0]    F_Start,
   input  logic [FW_W-1:0]    F_Stop,
   input  logic [FW_W-1:0]    F_Step,
   input  logic [DWELL_W-1:0] Dwell,
   output logic [FW_W-1:0]    Fword,
   output logic               Busy,
   output logic               Step_Strobe,
   output logic               Sweep_Done,
   output logic               Dbg_State
);

   typedef enum logic {S_IDLE = 1'b0, S_DWELL = 1'b1} state_t;

   state_t             r_state, w_state_nxt;
   logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
   logic [FW_W-1:0]    r_fword, w_fword_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_strobe, w_strobe_nxt;
   logic               r_done, w_done_nxt;

   logic [FW_W-1:0]    r_start_s, r_stop_s, r_step_s;
   logic [DWELL_W-1:0] r_dwell_s;
   logic               r_cont_s, r_up_s;

   logic               w_go;
   logic [FW_W:0]      w_sum, w_diff;
   logic [FW_W-1:0]    w_next;

   // A simultaneous Stop suppresses the start request.
   assign w_go = (r_state == S_IDLE) && Start && !Stop;

   // Extra top bit catches carry (up) or borrow (down); both clamp to the stop word.
   assign w_sum  = {1'b0, r_fword} + {1'b0, r_step_s};
   assign w_diff = {1'b0, r_fword} - {1'b0, r_step_s};

   always_comb begin
      w_next = r_stop_s;
      if (r_up_s) begin
         if (!w_sum[FW_W] && (w_sum[FW_W-1:0] <= r_stop_s))
            w_next = w_sum[FW_W-1:0];
      end else begin
         if (!w_diff[FW_W] && (w_diff[FW_W-1:0] >= r_stop_s))
            w_next = w_diff[FW_W-1:0];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_start_s <= '0;
         r_stop_s  <= '0;
         r_step_s  <= '0;
         r_dwell_s <= '0;
         r_cont_s  <= 1'b0;
         r_up_s    <= 1'b0;
      end else if (w_go) begin
         r_start_s <= F_Start;
         r_stop_s  <= F_Stop;
         r_step_s  <= (F_Step == '0) ? FW_W'(1) : F_Step;
         r_dwell_s <= Dwell;
         r_cont_s  <= Cont;
         r_up_s    <= (F_Stop >= F_Start);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_fword_nxt  = r_fword;
      w_busy_nxt   = r_busy;
      w_strobe_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_state_nxt  = S_DWELL;
               w_cnt_nxt    = '0;
               w_fword_nxt  = F_Start;
               w_busy_nxt   = 1'b1;
               w_strobe_nxt = 1'b1;
            end
         end
         S_DWELL: begin
            if (Stop) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end else if (r_cnt == r_dwell_s) begin
               w_cnt_nxt = '0;
               if (r_fword != r_stop_s) begin
                  w_fword_nxt  = w_next;
                  w_strobe_nxt = 1'b1;
               end else begin
                  w_done_nxt = 1'b1;
                  if (r_cont_s) begin
                     w_fword_nxt  = r_start_s;
                     w_strobe_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_busy_nxt  = 1'b0;
                  end
               end
            end else begin
               w_cnt_nxt = r_cnt + DWELL_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_fword  <= '0;
         r_busy   <= 1'b0;
         r_strobe <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_fword  <= w_fword_nxt;
         r_busy   <= w_busy_nxt;
         r_strobe <= w_strobe_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign Fword       = r_fword;
   assign Busy        = r_busy;
   assign Step_Strobe = r_strobe;
   assign Sweep_Done  = r_done;
   assign Dbg_State   = r_state;

endmodule
